pong_match_controller: RTL and testbench

Game-flow sequencer for the Pong datapath. It decides when the ball may move, when it is re-served, and how lives, score and ball speed evolve across a match. All timing is frame-based, using the end-of-frame pulse from the pixel/ball logic. Its outputs gate ball motion, trigger ball re-centering and feed the score/status display.

---
 rtl/pong_match_controller_if.sv | 26 ++
 rtl/pong_match_controller.sv | 170 +++++++++++++++++
 tb/tb_pong_match_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pong_match_controller_if.sv
// Game-flow bus for the Pong match controller: event inputs in, ball control and status out.
interface pong_match_controller_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic               frame_tick;
  logic               hit;
  logic               miss;
  logic               ball_run;
  logic               ball_serve;
  logic [1:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [2:0]         speed;
  logic [2:0]         state;
  logic               game_over;

  modport master (
    output start, frame_tick, hit, miss,
    input  ball_run, ball_serve, lives, score, speed, state, game_over
  );

  modport slave (
    input  start, frame_tick, hit, miss,
    output ball_run, ball_serve, lives, score, speed, state, game_over
  );
endinterface

// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve/play/miss/over flow, lives, score and ball speed; all outputs registered.
// Optional speed-up on paddle hits when SPEEDUP_EN is defined (default build: speed fixed at 1).
module pong_match_controller #(
  parameter int LIVES          = 3,
  parameter int SERVE_FRAMES   = 60,
  parameter int MISS_FRAMES    = 63,
  parameter int SCORE_W        = 8,
  parameter int HITS_PER_LEVEL = 5,
  parameter int MAX_SPEED      = 4
) (
  input logic Clock,
  input logic Reset,
  pong_match_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int MAXF  = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int CNT_W = (MAXF > 1) ? $clog2(MAXF) : 1;
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] MISS_LOAD  = CNT_W'(MISS_FRAMES - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
  // Base speed is 1 unless the ceiling itself is configured lower.
  localparam logic [2:0]       MIN_SPEED  = (MAX_SPEED < 1) ? 3'(MAX_SPEED) : 3'd1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               run_q, run_d;
  logic               serve_q, serve_d;
  logic               over_q, over_d;
  logic               start_q;
  logic               start_edge;

`ifdef SPEEDUP_EN
  localparam int HC_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HITS_PER_LEVEL - 1);
  localparam logic [2:0]      SPEED_CAP = 3'(MAX_SPEED);
  logic [HC_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [2:0]      speed_q, speed_d;
`endif

  assign start_edge = bus.start & ~start_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lives_q <= LIVES_INIT;
      score_q <= '0;
      run_q   <= 1'b0;
      serve_q <= 1'b0;
      over_q  <= 1'b0;
      start_q <= 1'b1;
`ifdef SPEEDUP_EN
      hit_cnt_q <= '0;
      speed_q   <= MIN_SPEED;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
      score_q <= score_d;
      run_q   <= run_d;
      serve_q <= serve_d;
      over_q  <= over_d;
      start_q <= bus.start;
`ifdef SPEEDUP_EN
      hit_cnt_q <= hit_cnt_d;
      speed_q   <= speed_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    score_d = score_q;
    serve_d = 1'b0;
`ifdef SPEEDUP_EN
    hit_cnt_d = hit_cnt_q;
    speed_d   = speed_q;
`endif
    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          state_d = SERVE;
          lives_d = LIVES_INIT;
          score_d = '0;
          cnt_d   = SERVE_LOAD;
          serve_d = 1'b1;
`ifdef SPEEDUP_EN
          hit_cnt_d = '0;
          speed_d   = MIN_SPEED;
`endif
        end
      end
      SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_q == '0) state_d = PLAY;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      PLAY: begin
        // A miss in the same cycle as a hit discards the hit.
        if (bus.miss) begin
          lives_d = lives_q - 2'd1;
          cnt_d   = MISS_LOAD;
          state_d = MISS;
        end else if (bus.hit) begin
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
`ifdef SPEEDUP_EN
          if (hit_cnt_q == HC_LAST) begin
            hit_cnt_d = '0;
            if (speed_q < SPEED_CAP) speed_d = speed_q + 3'd1;
          end else begin
            hit_cnt_d = hit_cnt_q + HC_W'(1);
          end
`endif
        end
      end
      MISS: begin
        if (bus.frame_tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (lives_q == 2'd0) begin
            state_d = OVER;
          end else begin
            state_d = SERVE;
            cnt_d   = SERVE_LOAD;
            serve_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        lives_d = LIVES_INIT;
        score_d = '0;
`ifdef SPEEDUP_EN
        hit_cnt_d = '0;
        speed_d   = MIN_SPEED;
`endif
      end
    endcase
    run_d  = (state_d == PLAY);
    over_d = (state_d == OVER);
  end

  assign bus.state      = state_q;
  assign bus.ball_run   = run_q;
  assign bus.ball_serve = serve_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.game_over  = over_q;
`ifdef SPEEDUP_EN
  assign bus.speed      = speed_q;
`else
  assign bus.speed      = MIN_SPEED;
`endif

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller: reset/start vector table plus hand-written match sequences.
module tb_pong_match_controller;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  pong_match_controller_if #(.SCORE_W(8)) bus ();

  pong_match_controller #(
    .LIVES(3), .SERVE_FRAMES(60), .MISS_FRAMES(63),
    .SCORE_W(8), .HITS_PER_LEVEL(5), .MAX_SPEED(4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         rst, start, ft, hit, miss;
    logic [2:0] st;
    bit         run, serve;
    logic [1:0] lv;
    logic [7:0] sc;
    bit         go;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [2:0] st, input bit run, input bit serve,
                         input logic [1:0] lv, input logic [7:0] sc, input bit go);
    chk({name, ".state"},      32'(bus.state),      32'(st));
    chk({name, ".ball_run"},   32'(bus.ball_run),   32'(run));
    chk({name, ".ball_serve"}, 32'(bus.ball_serve), 32'(serve));
    chk({name, ".lives"},      32'(bus.lives),      32'(lv));
    chk({name, ".score"},      32'(bus.score),      32'(sc));
    chk({name, ".game_over"},  32'(bus.game_over),  32'(go));
  endtask

  // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
  task automatic step(input bit r, input bit s, input bit f, input bit h, input bit m);
    Reset          = r;
    bus.start      = s;
    bus.frame_tick = f;
    bus.hit        = h;
    bus.miss       = m;
    @(posedge Clock);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
    end
  endtask

  function automatic int exp_speed(input int nhits);
`ifdef SPEEDUP_EN
    int s;
    s = 1 + nhits / 5;
    return (s > 4) ? 4 : s;
`else
    return (nhits >= 0) ? 1 : 0;
`endif
  endfunction

  initial begin
    //          rst st ft h  m   state run srv lv sc go
    vt[0] = '{1, 1, 0, 0, 0, 3'd0, 0, 0, 2'd3, 8'd0, 0};
    vt[1] = '{0, 1, 0, 0, 0, 3'd0, 0, 0, 2'd3, 8'd0, 0};
    vt[2] = '{0, 0, 0, 0, 0, 3'd0, 0, 0, 2'd3, 8'd0, 0};
    vt[3] = '{0, 1, 0, 0, 0, 3'd1, 0, 1, 2'd3, 8'd0, 0};
    vt[4] = '{0, 1, 0, 0, 0, 3'd1, 0, 0, 2'd3, 8'd0, 0};
    vt[5] = '{0, 0, 0, 1, 0, 3'd1, 0, 0, 2'd3, 8'd0, 0};
    vt[6] = '{0, 0, 0, 0, 1, 3'd1, 0, 0, 2'd3, 8'd0, 0};

    for (int i = 0; i < 7; i++) begin
      step(vt[i].rst, vt[i].start, vt[i].ft, vt[i].hit, vt[i].miss);
      chk_all($sformatf("vec%0d", i), vt[i].st, vt[i].run, vt[i].serve, vt[i].lv, vt[i].sc, vt[i].go);
    end
    chk("reset_speed", 32'(bus.speed), 32'd1);

    // Serve: frozen for exactly 60 ticks.
    for (int k = 1; k <= 60; k++) begin
      step(0, 0, 1, 0, 0);
      if (k < 60) begin
        chk($sformatf("serve_tick%0d.run", k), 32'(bus.ball_run), 32'd0);
        chk($sformatf("serve_tick%0d.state", k), 32'(bus.state), 32'd1);
      end else begin
        chk_all("serve_done", 3'd2, 1, 0, 2'd3, 8'd0, 0);
      end
      step(0, 0, 0, 0, 0);
    end

    // Start edge and frame ticks are ignored in PLAY.
    step(0, 1, 1, 0, 0);
    chk_all("play_ignore", 3'd2, 1, 0, 2'd3, 8'd0, 0);
    step(0, 0, 0, 0, 0);

    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 1, 0);
      chk($sformatf("hit%0d.score", k), 32'(bus.score), 32'(k));
      step(0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 1, 1);
    chk_all("hit_and_miss", 3'd3, 0, 0, 2'd2, 8'd3, 0);
    step(0, 0, 0, 1, 0);
    chk("miss_ignores_hit", 32'(bus.score), 32'd3);

    frames(62);
    chk("miss_tick62.state", 32'(bus.state), 32'd3);
    step(0, 0, 1, 0, 0);
    chk_all("miss_expire1", 3'd1, 0, 1, 2'd2, 8'd3, 0);
    step(0, 0, 0, 0, 0);
    chk("serve_pulse_one_cycle", 32'(bus.ball_serve), 32'd0);

    frames(60);
    chk("play2.state", 32'(bus.state), 32'd2);
    step(0, 0, 0, 0, 1);
    chk_all("miss2", 3'd3, 0, 0, 2'd1, 8'd3, 0);
    frames(63);
    chk_all("serve3", 3'd1, 0, 0, 2'd1, 8'd3, 0);
    frames(60);
    step(0, 0, 0, 0, 1);
    chk_all("miss3", 3'd3, 0, 0, 2'd0, 8'd3, 0);
    frames(62);
    chk("miss3_tick62.state", 32'(bus.state), 32'd3);
    step(0, 0, 1, 0, 0);
    chk_all("game_over", 3'd4, 0, 0, 2'd0, 8'd3, 1);

    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    chk_all("over_ignores", 3'd4, 0, 0, 2'd0, 8'd3, 1);

    step(0, 1, 0, 0, 0);
    chk_all("restart", 3'd1, 0, 1, 2'd3, 8'd0, 0);
    step(0, 0, 0, 0, 0);
    frames(60);
    chk("restart_play.state", 32'(bus.state), 32'd2);
    hits(7);
    chk("score7", 32'(bus.score), 32'd7);

    step(1, 0, 0, 0, 0);
    chk_all("mid_reset", 3'd0, 0, 0, 2'd3, 8'd0, 0);

    // New match for speed and score saturation.
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("match3_serve", 32'(bus.ball_serve), 32'd1);
    step(0, 0, 0, 0, 0);
    frames(60);
    chk("match3_play.state", 32'(bus.state), 32'd2);
    for (int g = 1; g <= 4; g++) begin
      hits(5);
      chk($sformatf("speed_after_%0d_hits", g * 5), 32'(bus.speed), 32'(exp_speed(g * 5)));
    end
    chk("score20", 32'(bus.score), 32'd20);
    hits(235);
    chk("score255", 32'(bus.score), 32'd255);
    step(0, 0, 0, 1, 0);
    chk("score_saturates", 32'(bus.score), 32'd255);
    chk("speed_final", 32'(bus.speed), 32'(exp_speed(256)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
